imem_sequencer: RTL

- Owns a small instruction memory fed by the assembler.
- In load mode (mode=1), it captures each 32-bit inst on a rising edge of store_clk.
- In run mode (mode=0), it replays the stored program to the execute datapath over a valid/ready handshake, following jump instructions.
- Sits between the assembler and the add/jump execute unit.

---
 rtl/imem_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/imem_sequencer.sv
// Purpose : instruction memory loaded by the assembler, replayed to the execute unit with jumps.
// Latency : first ex_valid 2 cycles after mode falls; one instruction per 2 cycles when ready.
// Backpr. : ex_valid/ex_inst hold stable until ex_ready; load requests wait for the handshake.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   mode              1 = load program, 0 = run
//   store_clk/inst_in assembler store strobe (rising edge = store) and instruction
//   ex_inst/ex_valid  instruction presented to the execute unit, ex_ready accepts it
//   pc, prog_len      current/last fetched address, number of stored instructions
//   busy, done        in LOAD/FETCH/ISSUE, in HALT
//   ovf, jmp_err      sticky: store dropped on full memory, jump beyond program
module imem_sequencer #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              store_clk,
  input  logic [31:0]       inst_in,
  output logic [31:0]       ex_inst,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W:0]   prog_len,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic              jmp_err
);

  localparam int             DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_ISSUE,
    S_HALT
  } state_e;

  state_e              state_q;
  logic                store_clk_q;
  logic [31:0]         ex_inst_q;
  logic                ex_valid_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W:0]     prog_len_q;
  logic                ovf_q;
  logic                jmp_err_q;
  logic [31:0]         mem_q [DEPTH];

  logic                store_edge;
  logic                mem_full;
  logic                mem_we;
  logic [ADDR_W:0]     prog_len_d;
  logic [ADDR_W-1:0]   jmp_tgt;
  logic                jmp_ok;
  logic [ADDR_W:0]     pc_inc;
  logic                hs;

  assign store_edge = store_clk & ~store_clk_q;
  assign mem_full   = (prog_len_q == DEPTH_C);
  assign mem_we     = (state_q == S_LOAD) && store_edge && !mem_full;
  // Length including a store landing this cycle, so a store coinciding with
  // mode falling still counts when deciding between IDLE and FETCH.
  assign prog_len_d = prog_len_q + (ADDR_W + 1)'(mem_we);
  assign jmp_tgt    = ex_inst_q[ADDR_W-1:0];
  assign jmp_ok     = ({1'b0, jmp_tgt} < prog_len_q);
  assign pc_inc     = {1'b0, pc_q} + (ADDR_W + 1)'(1);
  assign hs         = ex_valid_q & ex_ready;

  // Program storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[prog_len_q[ADDR_W-1:0]] <= inst_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      store_clk_q <= 1'b0;
      ex_inst_q   <= '0;
      ex_valid_q  <= 1'b0;
      pc_q        <= '0;
      prog_len_q  <= '0;
      ovf_q       <= 1'b0;
      jmp_err_q   <= 1'b0;
    end else begin
      store_clk_q <= store_clk;
      case (state_q)
        S_IDLE: begin
          if (mode) begin
            state_q    <= S_LOAD;
            prog_len_q <= '0;
            ovf_q      <= 1'b0;
            jmp_err_q  <= 1'b0;
          end
        end
        S_LOAD: begin
          prog_len_q <= prog_len_d;
          if (store_edge && mem_full) ovf_q <= 1'b1;
          if (!mode) begin
            if (prog_len_d == '0) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_FETCH;
              pc_q    <= '0;
            end
          end
        end
        S_FETCH: begin
          if (mode) begin
            state_q    <= S_LOAD;
            prog_len_q <= '0;
            ovf_q      <= 1'b0;
            jmp_err_q  <= 1'b0;
          end else begin
            ex_inst_q  <= mem_q[pc_q];
            ex_valid_q <= 1'b1;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // mode is only looked at once the handshake completes.
          if (hs) begin
            ex_valid_q <= 1'b0;
            if (ex_inst_q[30] && !jmp_ok) begin
              jmp_err_q <= 1'b1;
              state_q   <= S_HALT;
            end else if (!ex_inst_q[30] && (pc_inc == prog_len_q)) begin
              state_q <= S_HALT;
            end else begin
              pc_q <= ex_inst_q[30] ? jmp_tgt : pc_inc[ADDR_W-1:0];
              if (mode) begin
                state_q    <= S_LOAD;
                prog_len_q <= '0;
                ovf_q      <= 1'b0;
                jmp_err_q  <= 1'b0;
              end else begin
                state_q <= S_FETCH;
              end
            end
          end
        end
        S_HALT: begin
          if (mode) begin
            state_q    <= S_LOAD;
            prog_len_q <= '0;
            ovf_q      <= 1'b0;
            jmp_err_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ex_inst  = ex_inst_q;
  assign ex_valid = ex_valid_q;
  assign pc       = pc_q;
  assign prog_len = prog_len_q;
  assign busy     = (state_q == S_LOAD) || (state_q == S_FETCH) || (state_q == S_ISSUE);
  assign done     = (state_q == S_HALT);
  assign ovf      = ovf_q;
  assign jmp_err  = jmp_err_q;

endmodule
